// File: rtl/assoc_refill_pkg.sv
// Shared types and default widths for the associative-bank refill controller.
package assoc_refill_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    MEM_WAIT,
    FILL,
    RESP
  } state_t;

endpackage

// File: rtl/assoc_refill_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, hold at all-ones, clear has priority over inc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/assoc_refill_ctrl.sv
// Lookup/refill controller in front of the associative bank: one request at
// a time, bank lookup, memory refill on miss, hit/miss performance counters.
module assoc_refill_ctrl
  import assoc_refill_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_hit,
  output logic [ADDR_WIDTH-1:0] bank_raddr,
  input  logic [DATA_WIDTH-1:0] bank_rdata,
  input  logic                  bank_hit,
  output logic                  bank_we,
  output logic [ADDR_WIDTH-1:0] bank_waddr,
  output logic [DATA_WIDTH-1:0] bank_wdata,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  hit_q;
  // Low while reset is held and until the first edge after release, so that
  // req_ready and bank_raddr read as 0 during reset even though state is IDLE.
  logic                  run_q;
  logic                  accept;
  logic                  hit_inc;
  logic                  miss_inc;

  assign req_ready    = run_q && (state == IDLE);
  assign accept       = req_valid && req_ready;
  // In IDLE the request address goes straight to the registered bank port so
  // the lookup result is ready in LOOKUP; afterwards the latched copy holds it.
  assign bank_raddr   = req_ready ? req_addr : addr_q;
  assign bank_waddr   = addr_q;
  assign bank_wdata   = data_q;
  assign mem_req_addr = addr_q;
  assign resp_data    = data_q;
  assign resp_hit     = hit_q;
  assign hit_inc      = (state == LOOKUP) && bank_hit;
  assign miss_inc     = (state == LOOKUP) && !bank_hit;

  // State register plus the datapath registers loaded on FSM transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      hit_q  <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      state <= state_next;
      run_q <= 1'b1;
      if (accept) begin
        addr_q <= req_addr;
      end
      if ((state == LOOKUP) && bank_hit) begin
        data_q <= bank_rdata;
        hit_q  <= 1'b1;
      end
      if ((state == MEM_WAIT) && mem_resp_valid) begin
        data_q <= mem_resp_data;
        hit_q  <= 1'b0;
      end
    end
  end

  // Next-state and Moore strobes; memory responses outside MEM_WAIT are dropped.
  always_comb begin
    state_next    = state;
    mem_req_valid = 1'b0;
    bank_we       = 1'b0;
    resp_valid    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_next = LOOKUP;
      end
      LOOKUP: begin
        state_next = bank_hit ? RESP : MEM_REQ;
      end
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_resp_valid) state_next = FILL;
      end
      FILL: begin
        bank_we    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .clear (1'b0),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .clear (1'b0),
    .count (miss_count)
  );

endmodule

// File: tb/tb_assoc_refill_ctrl.sv
// Directed testbench for assoc_refill_ctrl with a small registered bank model.
module tb_assoc_refill_ctrl;
  import assoc_refill_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] bank_rdata;
  logic          bank_hit;
  logic          mem_req_ready = 1'b0;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_resp_data = '0;

  logic          req_ready, resp_valid, resp_hit, bank_we, mem_req_valid;
  logic [DW-1:0] resp_data, bank_wdata;
  logic [AW-1:0] bank_raddr, bank_waddr, mem_req_addr;
  logic [15:0]   hit_count, miss_count;

  logic          s_req_ready, s_resp_valid, s_resp_hit, s_bank_we, s_mem_req_valid;
  logic [DW-1:0] s_resp_data, s_bank_wdata;
  logic [AW-1:0] s_bank_raddr, s_bank_waddr, s_mem_req_addr;
  logic [1:0]    s_hit_count, s_miss_count;

  // Bank model: hit pattern set by the tests, data remembers refills and
  // otherwise returns {addr,addr} in the low byte.
  logic [DW-1:0] bmem [16];
  logic [15:0]   bwritten = '0;
  logic [15:0]   hit_mask = '0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bank_we) begin
      bmem[bank_waddr]     <= bank_wdata;
      bwritten[bank_waddr] <= 1'b1;
    end
    bank_rdata <= bwritten[bank_raddr] ? bmem[bank_raddr] : {24'h0, bank_raddr, bank_raddr};
    bank_hit   <= hit_mask[bank_raddr];
  end

  assoc_refill_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
    .bank_raddr(bank_raddr), .bank_rdata(bank_rdata), .bank_hit(bank_hit),
    .bank_we(bank_we), .bank_waddr(bank_waddr), .bank_wdata(bank_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Narrow-counter instance sharing all inputs, used for saturation.
  assoc_refill_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(s_req_ready),
    .resp_valid(s_resp_valid), .resp_data(s_resp_data), .resp_hit(s_resp_hit),
    .bank_raddr(s_bank_raddr), .bank_rdata(bank_rdata), .bank_hit(bank_hit),
    .bank_we(s_bank_we), .bank_waddr(s_bank_waddr), .bank_wdata(s_bank_wdata),
    .mem_req_valid(s_mem_req_valid), .mem_req_addr(s_mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({req_ready, resp_valid, bank_we, mem_req_valid} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_strobes: got %b expected 0000", {req_ready, resp_valid, bank_we, mem_req_valid});
    end
    checks++;
    if ({hit_count, miss_count, bank_raddr, resp_data, resp_hit} !== '0) begin
      fails++;
      $display("FAIL reset_regs: hit=%0d miss=%0d raddr=%h data=%h rhit=%b expected all 0",
               hit_count, miss_count, bank_raddr, resp_data, resp_hit);
    end
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_reset_mid_refill();
    int bad;
    hit_mask[3] = 1'b0;
    req_addr  = 4'h3;
    req_valid = 1'b1;
    step();                      // accepted -> LOOKUP
    req_valid = 1'b0;
    step();                      // MEM_REQ
    mem_req_ready = 1'b1;
    step();                      // MEM_WAIT
    mem_req_ready = 1'b0;
    checks++;
    if (dut.state !== MEM_WAIT) begin
      fails++;
      $display("FAIL midrefill_in_wait: got %s expected MEM_WAIT", dut.state.name());
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ((dut.state !== IDLE) || (miss_count !== 16'd0)) begin
      fails++;
      $display("FAIL midrefill_async: state=%s miss=%0d expected IDLE/0", dut.state.name(), miss_count);
    end
    step();
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0BAD;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bank_we || resp_valid) bad++;
    end
    mem_resp_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL midrefill_stray: got %0d strobe cycles expected 0", bad);
    end
    checks++;
    if ((dut.state !== IDLE) || (hit_count !== 16'd0) || (miss_count !== 16'd0)) begin
      fails++;
      $display("FAIL midrefill_after: state=%s hit=%0d miss=%0d expected IDLE/0/0",
               dut.state.name(), hit_count, miss_count);
    end
    $display("test_reset_mid_refill done");
  endtask

  task automatic test_cold_miss();
    hit_mask[5] = 1'b0;
    req_addr  = 4'h5;
    req_valid = 1'b1;
    step();                      // LOOKUP
    req_valid = 1'b0;
    step();                      // MEM_REQ
    checks++;
    if ((mem_req_valid !== 1'b1) || (mem_req_addr !== 4'h5)) begin
      fails++;
      $display("FAIL miss_memreq: valid=%b addr=%h expected 1/5", mem_req_valid, mem_req_addr);
    end
    step();
    step();
    mem_req_ready = 1'b1;
    step();                      // MEM_WAIT
    mem_req_ready = 1'b0;
    step();
    step();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEAD_BEEF;
    step();                      // FILL
    mem_resp_valid = 1'b0;
    checks++;
    if ((bank_we !== 1'b1) || (bank_waddr !== 4'h5) || (bank_wdata !== 32'hDEAD_BEEF) || resp_valid) begin
      fails++;
      $display("FAIL miss_fill: we=%b waddr=%h wdata=%h rv=%b expected 1/5/deadbeef/0",
               bank_we, bank_waddr, bank_wdata, resp_valid);
    end
    step();                      // RESP
    checks++;
    if ((resp_valid !== 1'b1) || (resp_data !== 32'hDEAD_BEEF) || (resp_hit !== 1'b0) || (bank_we !== 1'b0)) begin
      fails++;
      $display("FAIL miss_resp: rv=%b data=%h hit=%b we=%b expected 1/deadbeef/0/0",
               resp_valid, resp_data, resp_hit, bank_we);
    end
    checks++;
    if (miss_count !== 16'd1) begin
      fails++;
      $display("FAIL miss_count: got %0d expected 1", miss_count);
    end
    step();                      // IDLE
    $display("test_cold_miss done");
  endtask

  task automatic test_hit();
    hit_mask[5] = 1'b1;
    req_addr  = 4'h5;
    req_valid = 1'b1;
    step();                      // LOOKUP (cycle 2 of 3)
    req_valid = 1'b0;
    checks++;
    if ((resp_valid !== 1'b0) || (mem_req_valid !== 1'b0)) begin
      fails++;
      $display("FAIL hit_early: rv=%b mrv=%b expected 0/0", resp_valid, mem_req_valid);
    end
    step();                      // RESP (cycle 3)
    checks++;
    if ((resp_valid !== 1'b1) || (resp_hit !== 1'b1) || (resp_data !== 32'hDEAD_BEEF) || mem_req_valid) begin
      fails++;
      $display("FAIL hit_resp: rv=%b hit=%b data=%h mrv=%b expected 1/1/deadbeef/0",
               resp_valid, resp_hit, resp_data, mem_req_valid);
    end
    checks++;
    if ((hit_count !== 16'd1) || (miss_count !== 16'd1)) begin
      fails++;
      $display("FAIL hit_count: hit=%0d miss=%0d expected 1/1", hit_count, miss_count);
    end
    step();
    checks++;
    if ((resp_valid !== 1'b0) || (req_ready !== 1'b1)) begin
      fails++;
      $display("FAIL hit_pulse_end: rv=%b ready=%b expected 0/1", resp_valid, req_ready);
    end
    $display("test_hit done");
  endtask

  task automatic test_backpressure();
    int bad;
    hit_mask[9] = 1'b0;
    req_addr  = 4'h9;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();                      // MEM_REQ
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if ((mem_req_valid !== 1'b1) || (mem_req_addr !== 4'h9) || (req_ready !== 1'b0)) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", bad);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0099;
    step();                      // FILL
    mem_resp_valid = 1'b0;
    step();                      // RESP
    checks++;
    if ((resp_valid !== 1'b1) || (resp_data !== 32'h0000_0099) || (miss_count !== 16'd2)) begin
      fails++;
      $display("FAIL backpressure_resp: rv=%b data=%h miss=%0d expected 1/00000099/2",
               resp_valid, resp_data, miss_count);
    end
    step();
    $display("test_backpressure done");
  endtask

  task automatic test_busy();
    hit_mask[10] = 1'b0;
    hit_mask[7]  = 1'b1;
    req_addr  = 4'hA;
    req_valid = 1'b1;
    step();                      // LOOKUP for 0xA
    req_addr       = 4'h7;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hAAAA_0000;
    for (int i = 0; i < 3; i++) begin  // LOOKUP, MEM_REQ, MEM_WAIT
      checks++;
      if (req_ready !== 1'b0) begin
        fails++;
        $display("FAIL busy_ready_%0d: got %b expected 0", i, req_ready);
      end
      step();
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    checks++;                     // FILL
    if ((bank_we !== 1'b1) || (bank_waddr !== 4'hA) || (req_ready !== 1'b0)) begin
      fails++;
      $display("FAIL busy_fill: we=%b waddr=%h ready=%b expected 1/a/0", bank_we, bank_waddr, req_ready);
    end
    step();                      // RESP
    checks++;
    if ((resp_valid !== 1'b1) || (resp_data !== 32'hAAAA_0000) || (req_ready !== 1'b0)) begin
      fails++;
      $display("FAIL busy_resp: rv=%b data=%h ready=%b expected 1/aaaa0000/0", resp_valid, resp_data, req_ready);
    end
    step();                      // IDLE, 0x7 accepted at the coming edge
    checks++;
    if ((req_ready !== 1'b1) || (bank_raddr !== 4'h7) || (resp_valid !== 1'b0)) begin
      fails++;
      $display("FAIL busy_idle: ready=%b raddr=%h rv=%b expected 1/7/0", req_ready, bank_raddr, resp_valid);
    end
    step();                      // LOOKUP for 0x7
    req_valid = 1'b0;
    checks++;
    if ((req_ready !== 1'b0) || (bank_raddr !== 4'h7)) begin
      fails++;
      $display("FAIL busy_accept7: ready=%b raddr=%h expected 0/7", req_ready, bank_raddr);
    end
    step();                      // RESP
    checks++;
    if ((resp_valid !== 1'b1) || (resp_hit !== 1'b1) || (resp_data !== 32'h0000_0077) ||
        (hit_count !== 16'd2) || (miss_count !== 16'd3)) begin
      fails++;
      $display("FAIL busy_resp7: rv=%b hit=%b data=%h hc=%0d mc=%0d expected 1/1/00000077/2/3",
               resp_valid, resp_hit, resp_data, hit_count, miss_count);
    end
    step();
    $display("test_busy done");
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    hit_mask[5] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_sat   = (k < 3) ? 2'(k + 1) : 2'd3;
      req_addr  = 4'h5;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      step();                    // RESP
      checks++;
      if ((s_resp_valid !== 1'b1) || (s_hit_count !== exp_sat) || (hit_count !== 16'(k + 1))) begin
        fails++;
        $display("FAIL sat_hit_%0d: rv=%b narrow=%0d wide=%0d expected 1/%0d/%0d",
                 k, s_resp_valid, s_hit_count, hit_count, exp_sat, k + 1);
      end
      $display("sat hit %0d: narrow=%0d wide=%0d", k, s_hit_count, hit_count);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_refill();
    test_cold_miss();
    test_hit();
    test_backpressure();
    test_busy();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
